// File: rtl/fpu_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_op_sequencer_pkg
// Description : Shared types, widths and helpers for the FPU op sequencer.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef OR1K_FPUOP_WIDTH
`define OR1K_FPUOP_WIDTH 8
`endif
`ifndef OR1K_FPCSR_RM_SIZE
`define OR1K_FPCSR_RM_SIZE 2
`endif
`ifndef OR1K_FPCSR_WIDTH
`define OR1K_FPCSR_WIDTH 12
`endif

package fpu_op_sequencer_pkg;

    localparam int c_OP_W    = `OR1K_FPUOP_WIDTH;
    localparam int c_RM_W    = `OR1K_FPCSR_RM_SIZE;
    localparam int c_FPCSR_W = `OR1K_FPCSR_WIDTH;

    typedef enum logic [2:0] {
        S_FLUSH  = 3'd0,
        S_DRAIN  = 3'd1,
        S_IDLE   = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_WAIT   = 3'd5,
        S_RESP   = 3'd6
    } seq_state_t;

    typedef struct packed {
        logic [c_OP_W-1:0] op;
        logic [c_RM_W-1:0] rm;
        logic [31:0]       a;
        logic [31:0]       b;
    } fpu_req_t;

    typedef struct packed {
        logic [31:0]          result;
        logic                 cmp;
        logic [c_FPCSR_W-1:0] fpcsr;
        logic                 timeout;
    } fpu_rsp_t;

    // lf.sf* set-flag encodings all carry bit 3
    function automatic logic is_compare(input logic [c_OP_W-1:0] op);
        return op[3];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_seq_timer
// Description : Loadable WAIT-cycle counter with an expired flag; saturates at
//               TIMEOUT_CYCLES. Used only when FPU_SEQ_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================

module fpu_seq_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    logic [15:0] count_q;

    assign expired_o = (count_q == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset || load_i) begin
            count_q <= 16'd0;
        end else if (en_i && !expired_o) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_op_sequencer
// Description : Runs one FPU operation at a time: flush/drain, decode, execute,
//               wait for the matching valid, then hold the response.
//               Optional WAIT timeout enabled by defining FPU_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module fpu_op_sequencer
    import fpu_op_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [c_OP_W-1:0]    req_op,
    input  logic [c_RM_W-1:0]    req_rm,
    input  logic [31:0]          req_a,
    input  logic [31:0]          req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_result,
    output logic                 rsp_cmp,
    output logic [c_FPCSR_W-1:0] rsp_fpcsr,
    output logic                 rsp_timeout,
    output logic                 fpu_flush,
    output logic                 fpu_decode,
    output logic                 fpu_execute,
    output logic [c_OP_W-1:0]    fpu_op,
    output logic [c_RM_W-1:0]    fpu_rm,
    output logic [31:0]          fpu_opa,
    output logic [31:0]          fpu_opb,
    input  logic [31:0]          fpu_out,
    input  logic                 fpu_valid_arith,
    input  logic                 fpu_valid_cmp,
    input  logic                 fpu_cmp,
    input  logic [c_FPCSR_W-1:0] fpu_fpcsr
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 2..65535");
    end

    seq_state_t state_q;
    fpu_req_t   req_q;
    fpu_rsp_t   rsp_q;
    logic       req_ready_q;
    logic       rsp_valid_q;
    logic       flush_q;
    logic       decode_q;
    logic       execute_q;

    logic       w_is_cmp;
    logic       w_done;
    logic       w_expired;
    logic       w_fpu_quiet;

    assign w_is_cmp    = is_compare(req_q.op);
    assign w_done      = w_is_cmp ? fpu_valid_cmp : fpu_valid_arith;
    assign w_fpu_quiet = !fpu_valid_arith && !fpu_valid_cmp && (fpu_out == 32'd0);

`ifdef FPU_SEQ_TIMEOUT_EN
    logic w_timer_load;
    logic w_timer_en;

    assign w_timer_load = (state_q == S_EXEC);
    assign w_timer_en   = (state_q == S_WAIT);

    fpu_seq_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (w_timer_load),
        .en_i      (w_timer_en),
        .expired_o (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FLUSH;
            req_q       <= '0;
            rsp_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            flush_q     <= 1'b0;
            decode_q    <= 1'b0;
            execute_q   <= 1'b0;
        end else begin
            case (state_q)
                S_FLUSH: begin
                    // Arriving from reset the pulse is not yet up: raise it first
                    if (flush_q) begin
                        flush_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_fpu_quiet) begin
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        req_q       <= '{op: req_op, rm: req_rm, a: req_a, b: req_b};
                        req_ready_q <= 1'b0;
                        decode_q    <= 1'b1;
                        state_q     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    decode_q  <= 1'b0;
                    execute_q <= 1'b1;
                    state_q   <= S_EXEC;
                end
                S_EXEC: begin
                    execute_q <= 1'b0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    // A matching valid beats an expiry in the same cycle
                    if (w_done) begin
                        rsp_q       <= '{result:  w_is_cmp ? 32'd0 : fpu_out,
                                         cmp:     w_is_cmp ? fpu_cmp : 1'b0,
                                         fpcsr:   fpu_fpcsr,
                                         timeout: 1'b0};
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (w_expired) begin
                        rsp_q       <= '{result: 32'd0, cmp: 1'b0, fpcsr: '0, timeout: 1'b1};
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_q       <= '0;
                        req_q       <= '0;
                        flush_q     <= 1'b1;
                        state_q     <= S_FLUSH;
                    end
                end
                default: begin
                    flush_q <= 1'b0;
                    state_q <= S_FLUSH;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_q.result;
    assign rsp_cmp     = rsp_q.cmp;
    assign rsp_fpcsr   = rsp_q.fpcsr;
    assign rsp_timeout = rsp_q.timeout;
    assign fpu_flush   = flush_q;
    assign fpu_decode  = decode_q;
    assign fpu_execute = execute_q;
    assign fpu_op      = req_q.op;
    assign fpu_rm      = req_q.rm;
    assign fpu_opa     = req_q.a;
    assign fpu_opb     = req_q.b;

endmodule

`default_nettype wire

// File: tb/tb_fpu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_op_sequencer
// Description : Self-checking bench for fpu_op_sequencer with a scripted FPU
//               model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_fpu_op_sequencer;
    import fpu_op_sequencer_pkg::*;

    localparam int TO = 16;

    typedef struct {
        logic [c_OP_W-1:0]    op;
        logic [c_RM_W-1:0]    rm;
        logic [31:0]          a;
        logic [31:0]          b;
        logic [31:0]          res;
        logic                 cmpv;
        logic [c_FPCSR_W-1:0] flags;
        int                   lat;
        bit                   noise;
        int                   bp;
        int                   drain;
        bit                   keep;
    } op_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req_valid, req_ready;
    logic [c_OP_W-1:0]    req_op;
    logic [c_RM_W-1:0]    req_rm;
    logic [31:0]          req_a, req_b;
    logic                 rsp_valid, rsp_ready;
    logic [31:0]          rsp_result;
    logic                 rsp_cmp;
    logic [c_FPCSR_W-1:0] rsp_fpcsr;
    logic                 rsp_timeout;
    logic                 fpu_flush, fpu_decode, fpu_execute;
    logic [c_OP_W-1:0]    fpu_op;
    logic [c_RM_W-1:0]    fpu_rm;
    logic [31:0]          fpu_opa, fpu_opb;
    logic [31:0]          fpu_out;
    logic                 fpu_valid_arith, fpu_valid_cmp, fpu_cmp;
    logic [c_FPCSR_W-1:0] fpu_fpcsr;

    int       checks = 0;
    int       errors = 0;
    int       cyc    = 0;
    fpu_rsp_t sb_q[$];

    always #5 clk = ~clk;

    fpu_op_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_rm          (req_rm),
        .req_a           (req_a),
        .req_b           (req_b),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_result      (rsp_result),
        .rsp_cmp         (rsp_cmp),
        .rsp_fpcsr       (rsp_fpcsr),
        .rsp_timeout     (rsp_timeout),
        .fpu_flush       (fpu_flush),
        .fpu_decode      (fpu_decode),
        .fpu_execute     (fpu_execute),
        .fpu_op          (fpu_op),
        .fpu_rm          (fpu_rm),
        .fpu_opa         (fpu_opa),
        .fpu_opb         (fpu_opb),
        .fpu_out         (fpu_out),
        .fpu_valid_arith (fpu_valid_arith),
        .fpu_valid_cmp   (fpu_valid_cmp),
        .fpu_cmp         (fpu_cmp),
        .fpu_fpcsr       (fpu_fpcsr)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic any_out();
        return |{req_ready, rsp_valid, rsp_result, rsp_cmp, rsp_fpcsr, rsp_timeout,
                 fpu_flush, fpu_decode, fpu_execute, fpu_op, fpu_rm, fpu_opa, fpu_opb};
    endfunction

    function automatic op_t mk(input logic [7:0] op, input logic [1:0] rm,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic cmpv,
                               input logic [11:0] flags, input int lat, input bit noise,
                               input int bp, input int drain, input bit keep);
        op_t o;
        o.op = op; o.rm = rm; o.a = a; o.b = b; o.res = res; o.cmpv = cmpv;
        o.flags = flags; o.lat = lat; o.noise = noise; o.bp = bp;
        o.drain = drain; o.keep = keep;
        return o;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk_eq(tag, req_ready, 1'b1);
    endtask

    task automatic run_op(input op_t o);
        int       n;
        int       c_acc;
        int       exp_n;
        bit       ok;
        bit       to;
        fpu_rsp_t e;
        fpu_rsp_t got;

        req_op = o.op; req_rm = o.rm; req_a = o.a; req_b = o.b; req_valid = 1'b1;
        wait_ready("req_ready_seen");
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        tick();
        c_acc = cyc;

        to = 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
        to = (o.lat == 0) || (o.lat - 1 > TO);
`endif
        if (to) begin
            e = '{result: 32'd0, cmp: 1'b0, fpcsr: '0, timeout: 1'b1};
            exp_n = TO + 1;
        end else begin
            e = '{result: o.op[3] ? 32'd0 : o.res, cmp: o.op[3] ? o.cmpv : 1'b0,
                  fpcsr: o.flags, timeout: 1'b0};
            exp_n = o.lat;
        end
        sb_q.push_back(e);

        if (o.keep) begin
            req_a = ~o.a;
            req_b = ~o.b;
        end else begin
            req_valid = 1'b0;
        end

        chk_eq("decode_cycle", {fpu_decode, fpu_execute, req_ready}, 3'b100);
        chk_eq("operands_latched", {fpu_opa, fpu_opb}, {o.a, o.b});
        chk_eq("op_rm_latched", {fpu_op, fpu_rm}, {o.op, o.rm});
        tick();
        chk_eq("exec_cycle", {fpu_decode, fpu_execute}, 2'b01);
        tick();

        ok = 1'b1;
        n  = 0;
        while (!rsp_valid && n < 300) begin
            if (fpu_opa !== o.a || fpu_opb !== o.b || fpu_op !== o.op || fpu_rm !== o.rm ||
                fpu_decode || fpu_execute || req_ready || fpu_flush)
                ok = 1'b0;
            fpu_valid_arith = 1'b0;
            fpu_valid_cmp   = 1'b0;
            if (o.lat != 0 && n == o.lat - 1) begin
                fpu_fpcsr = o.flags;
                if (o.op[3]) begin
                    fpu_valid_cmp = 1'b1;
                    fpu_cmp       = o.cmpv;
                    fpu_out       = 32'h0BAD_F00D;
                end else begin
                    fpu_valid_arith = 1'b1;
                    fpu_out         = o.res;
                    fpu_cmp         = 1'b1;
                end
            end else if (o.noise && n == 0) begin
                fpu_fpcsr = '1;
                if (o.op[3]) begin
                    fpu_valid_arith = 1'b1;
                    fpu_out         = 32'hDEAD_BEEF;
                end else begin
                    fpu_valid_cmp = 1'b1;
                    fpu_cmp       = 1'b1;
                end
            end
            tick();
            n++;
        end
        fpu_valid_arith = 1'b0;
        fpu_valid_cmp   = 1'b0;
        chk_eq("wait_stable", ok, 1'b1);
        if (!rsp_valid) begin
            chk_eq("rsp_valid_bound", rsp_valid, 1'b1);
            return;
        end
        chk_eq("wait_cycles", n, exp_n);
        if (o.lat == 1) chk_eq("accept_to_rsp", cyc - c_acc + 1, 4);
        if (to) chk_eq("timeout_latency", cyc - c_acc + 1, TO + 4);

        e = sb_q.pop_front();
        got = '{result: rsp_result, cmp: rsp_cmp, fpcsr: rsp_fpcsr, timeout: rsp_timeout};
        chk_eq("rsp_result", got.result, e.result);
        chk_eq("rsp_cmp", got.cmp, e.cmp);
        chk_eq("rsp_fpcsr", got.fpcsr, e.fpcsr);
        chk_eq("rsp_timeout", got.timeout, e.timeout);

        // Disturb the FPU side to prove the response was captured
        fpu_cmp   = ~fpu_cmp;
        fpu_fpcsr = ~o.flags;
        rsp_ready = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < o.bp; i++) begin
            if (rsp_valid !== 1'b1 || rsp_result !== e.result || rsp_cmp !== e.cmp ||
                rsp_fpcsr !== e.fpcsr || rsp_timeout !== e.timeout || fpu_flush || req_ready)
                ok = 1'b0;
            tick();
        end
        if (o.bp > 0) chk_eq("backpressure_hold", ok, 1'b1);
        chk_eq("rsp_valid_at_hs", {rsp_valid, rsp_result}, {1'b1, e.result});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk_eq("flush_after_hs", {fpu_flush, rsp_valid, req_ready}, 3'b100);
        chk_eq("op_cleared_in_flush", {63'd0, |{fpu_op, fpu_rm, fpu_opa, fpu_opb}}, 64'd0);

        fpu_fpcsr = '0;
        fpu_cmp   = 1'b0;
        fpu_out   = (o.drain > 0) ? 32'h0000_1234 : 32'd0;
        tick();
        chk_eq("flush_one_cycle", {fpu_flush, req_ready}, 2'b00);
        for (int i = 0; i < o.drain; i++) begin
            chk_eq("drain_holds", req_ready, 1'b0);
            tick();
        end
        fpu_out = 32'd0;
        tick();
        chk_eq("ready_after_drain", req_ready, 1'b1);
    endtask

    task automatic reset_mid_wait();
        bit ok;
        req_op = 8'd0; req_rm = 2'd0; req_a = 32'h4000_0000; req_b = 32'h4000_0000;
        req_valid = 1'b1;
        wait_ready("rst_req_ready");
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk_eq("mid_wait_operand", {fpu_opa, rsp_valid, fpu_execute}, {32'h4000_0000, 2'b00});
        reset = 1'b1;
        fpu_valid_arith = 1'b1;
        fpu_out = 32'h4080_0000;
        tick();
        tick();
        chk_eq("outputs_zero_in_reset", any_out(), 1'b0);
        fpu_valid_arith = 1'b0;
        fpu_out = 32'd0;
        tick();
        chk_eq("outputs_zero_in_reset2", any_out(), 1'b0);
        reset = 1'b0;
        tick();
        chk_eq("flush_after_reset", {fpu_flush, req_ready}, 2'b10);
        ok = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) begin
            if (rsp_valid) ok = 1'b0;
            tick();
        end
        chk_eq("dropped_op_no_rsp", ok, 1'b1);
        chk_eq("ready_after_reset", req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_rm = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b0; fpu_out = '0; fpu_valid_arith = 1'b0; fpu_valid_cmp = 1'b0;
        fpu_cmp = 1'b0; fpu_fpcsr = '0;
        tick();
        tick();
        tick();
        chk_eq("reset_outputs_zero", any_out(), 1'b0);
        reset = 1'b0;
        tick();
        chk_eq("first_flush", {fpu_flush, req_ready}, 2'b10);
        tick();
        chk_eq("first_flush_ends", fpu_flush, 1'b0);
        wait_ready("initial_ready");

        // lf.add.s 1.0 + 2.0, single-cycle FPU
        run_op(mk(8'd0, 2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 12'h000, 1, 0, 0, 0, 0));
        // lf.sfeq.s 1.0 == 1.0 with a stray arith valid during WAIT
        run_op(mk(8'd8, 2'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 1'b1, 12'h000, 3, 1, 0, 0, 0));
        // lf.mul.s with stray compare valid, 10 cycles of backpressure, slow drain
        run_op(mk(8'd2, 2'd1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 12'h021, 2, 1, 10, 2, 0));
        // back-to-back: lf.sub.s with req_valid held, then lf.sflt.s
        run_op(mk(8'd1, 2'd2, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 12'h004, 4, 0, 0, 0, 1));
        run_op(mk(8'd12, 2'd3, 32'h3F80_0000, 32'h4000_0000, 32'h0, 1'b1, 12'h100, 1, 0, 0, 0, 0));
        // lf.sfgt.s false result
        run_op(mk(8'd10, 2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h0, 1'b0, 12'h002, 2, 0, 3, 0, 0));
        // lf.div.s with the valid landing on the expiry cycle
        run_op(mk(8'd3, 2'd0, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 12'h008, TO + 1, 0, 0, 0, 0));
`ifdef FPU_SEQ_TIMEOUT_EN
        // no valid at all: abort by timeout
        run_op(mk(8'd0, 2'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 12'h000, 0, 0, 2, 0, 0));
`endif
        reset_mid_wait();
        run_op(mk(8'd0, 2'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 12'h010, 1, 0, 0, 0, 0));

        chk_eq("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
